// File: rtl/dispensador_pkg.sv
// Shared types and default step timings for the beverage dispenser sequencer.
package dispensador_pkg;

    typedef enum logic [2:0] {
        OCIOSO,
        COPO,
        PO,
        AGUA,
        FIM,
        ERRO
    } estado_t;

    typedef enum logic {
        CAFE,
        SOPA
    } produto_t;

    localparam int CNT_W_DEF       = 8;
    localparam int T_COPO_DEF      = 4;
    localparam int T_PO_DEF        = 3;
    localparam int T_AGUA_CAFE_DEF = 8;
    localparam int T_AGUA_SOPA_DEF = 12;

endpackage

// File: rtl/contador_passo.sv
// Load-and-decrement step timer; fim flags the last cycle of the current step.
module contador_passo #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             carga,
    input  logic [CNT_W-1:0] valor,
    output logic             fim
);

    logic [CNT_W-1:0] cnt;

    // Holds at zero instead of wrapping once a step has ended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (carga) begin
            cnt <= valor;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign fim = (cnt == CNT_W'(1));

endmodule

// File: rtl/dispensador_bebida.sv
// Drink dispense sequencer: cup drop, cup check, powder, water, completion pulse.
module dispensador_bebida
    import dispensador_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int T_COPO      = T_COPO_DEF,
    parameter int T_PO        = T_PO_DEF,
    parameter int T_AGUA_CAFE = T_AGUA_CAFE_DEF,
    parameter int T_AGUA_SOPA = T_AGUA_SOPA_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cafe,
    input  logic sopa,
    input  logic copo_ok,
    input  logic limpa_erro,
    output logic pronto,
    output logic servindo,
    output logic motor_copo,
    output logic po_cafe,
    output logic po_sopa,
    output logic agua,
    output logic concluido,
    output logic erro
);

    localparam int T_MAX = (2 ** CNT_W) - 1;

    if (T_COPO < 1 || T_COPO > T_MAX || T_PO < 1 || T_PO > T_MAX ||
        T_AGUA_CAFE < 1 || T_AGUA_CAFE > T_MAX ||
        T_AGUA_SOPA < 1 || T_AGUA_SOPA > T_MAX) begin : g_chk_tempos
        $error("dispensador_bebida: step time out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] L_COPO      = CNT_W'(T_COPO);
    localparam logic [CNT_W-1:0] L_PO        = CNT_W'(T_PO);
    localparam logic [CNT_W-1:0] L_AGUA_CAFE = CNT_W'(T_AGUA_CAFE);
    localparam logic [CNT_W-1:0] L_AGUA_SOPA = CNT_W'(T_AGUA_SOPA);

    estado_t          estado, prox_estado;
    produto_t         produto, prox_produto;
    logic             cafe_ant, sopa_ant;
    logic             req_cafe, req_sopa;
    logic             carga;
    logic [CNT_W-1:0] valor_carga;
    logic             fim_passo;

    assign req_cafe = cafe & ~cafe_ant;
    assign req_sopa = sopa & ~sopa_ant;

    contador_passo #(.CNT_W(CNT_W)) u_contador (
        .clk   (clk),
        .rst_n (rst_n),
        .carga (carga),
        .valor (valor_carga),
        .fim   (fim_passo)
    );

    // Edge-detect history runs in every state so held commands never fire late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado   <= OCIOSO;
            produto  <= CAFE;
            cafe_ant <= 1'b0;
            sopa_ant <= 1'b0;
        end else begin
            estado   <= prox_estado;
            produto  <= prox_produto;
            cafe_ant <= cafe;
            sopa_ant <= sopa;
        end
    end

    always_comb begin
        prox_estado  = estado;
        prox_produto = produto;
        carga        = 1'b0;
        valor_carga  = '0;
        case (estado)
            OCIOSO: begin
                if (req_sopa || req_cafe) begin
                    prox_estado  = COPO;
                    prox_produto = req_sopa ? SOPA : CAFE;
                    carga        = 1'b1;
                    valor_carga  = L_COPO;
                end
            end
            COPO: begin
                if (fim_passo) begin
                    if (copo_ok) begin
                        prox_estado = PO;
                        carga       = 1'b1;
                        valor_carga = L_PO;
                    end else begin
                        prox_estado = ERRO;
                    end
                end
            end
            PO: begin
                if (fim_passo) begin
                    prox_estado = AGUA;
                    carga       = 1'b1;
                    valor_carga = (produto == SOPA) ? L_AGUA_SOPA : L_AGUA_CAFE;
                end
            end
            AGUA: begin
                if (fim_passo) begin
                    prox_estado = FIM;
                end
            end
            FIM:  prox_estado = OCIOSO;
            ERRO: begin
                if (limpa_erro) begin
                    prox_estado = OCIOSO;
                end
            end
            default: prox_estado = OCIOSO;
        endcase
    end

    // Output register: decoded from state and latched product, one cycle behind state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pronto     <= 1'b1;
            servindo   <= 1'b0;
            motor_copo <= 1'b0;
            po_cafe    <= 1'b0;
            po_sopa    <= 1'b0;
            agua       <= 1'b0;
            concluido  <= 1'b0;
            erro       <= 1'b0;
        end else begin
            pronto     <= (estado == OCIOSO);
            servindo   <= (estado == COPO) || (estado == PO) ||
                          (estado == AGUA) || (estado == FIM);
            motor_copo <= (estado == COPO);
            po_cafe    <= (estado == PO) && (produto == CAFE);
            po_sopa    <= (estado == PO) && (produto == SOPA);
            agua       <= (estado == AGUA);
            concluido  <= (estado == FIM);
            erro       <= (estado == ERRO);
        end
    end

endmodule

// File: tb/tb_dispensador_bebida.sv
// Directed table-driven bench for dispensador_bebida with default timings.
module tb_dispensador_bebida;

    logic clk = 1'b0;
    logic rst_n;
    logic cafe, sopa, copo_ok, limpa_erro;
    logic pronto, servindo, motor_copo, po_cafe, po_sopa, agua, concluido, erro;
    logic [7:0] saidas;

    int checks = 0;
    int errors = 0;

    // Output vector order: pronto servindo motor_copo po_cafe po_sopa agua concluido erro
    localparam logic [7:0] IDLE = 8'b1000_0000;
    localparam logic [7:0] MOT  = 8'b0110_0000;
    localparam logic [7:0] POC  = 8'b0101_0000;
    localparam logic [7:0] POS  = 8'b0100_1000;
    localparam logic [7:0] AGU  = 8'b0100_0100;
    localparam logic [7:0] FIMV = 8'b0100_0010;
    localparam logic [7:0] ERR  = 8'b0000_0001;

    typedef struct {
        logic       c;
        logic       s;
        logic       ok;
        logic       l;
        int         n;
        logic [7:0] exp;
    } vec_t;

    vec_t tab[$];

    dispensador_bebida dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cafe       (cafe),
        .sopa       (sopa),
        .copo_ok    (copo_ok),
        .limpa_erro (limpa_erro),
        .pronto     (pronto),
        .servindo   (servindo),
        .motor_copo (motor_copo),
        .po_cafe    (po_cafe),
        .po_sopa    (po_sopa),
        .agua       (agua),
        .concluido  (concluido),
        .erro       (erro)
    );

    assign saidas = {pronto, servindo, motor_copo, po_cafe, po_sopa, agua, concluido, erro};

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic add(input logic c, input logic s, input logic ok, input logic l,
                       input int n, input logic [7:0] exp);
        vec_t v;
        v.c = c; v.s = s; v.ok = ok; v.l = l; v.n = n; v.exp = exp;
        tab.push_back(v);
    endtask

    // Invariants sampled mid-cycle on every cycle out of reset
    logic conc_ant = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            conc_ant <= 1'b0;
        end else begin
            checks++;
            if (!$onehot0({motor_copo, po_cafe, po_sopa, agua})) begin
                errors++;
                $display("FAIL onehot_actuators: got %b required at most one high",
                         {motor_copo, po_cafe, po_sopa, agua});
            end
            if (servindo && pronto) begin
                errors++;
                $display("FAIL servindo_pronto: got both 1 required not both");
            end
            if (conc_ant && concluido) begin
                errors++;
                $display("FAIL concluido_pulse: got 1 for two cycles required one");
            end
            conc_ant <= concluido;
        end
    end

    initial begin
        rst_n = 1'b0; cafe = 1'b0; sopa = 1'b0; copo_ok = 1'b1; limpa_erro = 1'b0;

        // Coffee with cafe held throughout and a sopa edge during AGUA
        add(0,0,1,0, 2,IDLE); add(1,0,1,0, 1,IDLE); add(1,0,1,0, 4,MOT);
        add(1,0,1,0, 3,POC);  add(1,0,1,0, 4,AGU);  add(1,1,1,0, 4,AGU);
        add(1,1,1,0, 1,FIMV); add(1,1,1,0, 3,IDLE); add(0,0,1,0, 2,IDLE);
        // Soup; cup removed after the check does not abort
        add(0,1,1,0, 1,IDLE); add(0,1,1,0, 4,MOT);  add(0,1,0,0, 3,POS);
        add(0,1,0,0,12,AGU);  add(0,1,0,0, 1,FIMV); add(0,0,1,0, 2,IDLE);
        // Simultaneous edges select soup
        add(1,1,1,0, 1,IDLE); add(1,1,1,0, 4,MOT);  add(1,1,1,0, 3,POS);
        add(1,1,1,0,12,AGU);  add(1,1,1,0, 1,FIMV); add(0,0,1,0, 2,IDLE);
        // Cup missing, cafe held through the fault and the clear
        add(1,0,1,0, 1,IDLE); add(1,0,1,0, 3,MOT);  add(1,0,0,0, 1,MOT);
        add(1,0,0,0, 3,ERR);  add(1,0,0,1, 1,ERR);  add(1,0,1,0, 2,IDLE);
        add(0,0,1,0, 1,IDLE);
        // Fresh coffee after the fault
        add(1,0,1,0, 1,IDLE); add(1,0,1,0, 4,MOT);  add(1,0,1,0, 3,POC);
        add(1,0,1,0, 8,AGU);  add(1,0,1,0, 1,FIMV); add(0,0,1,0, 2,IDLE);

        #12;
        chk("reset_state", saidas, IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < tab.size(); r++) begin
            cafe = tab[r].c; sopa = tab[r].s; copo_ok = tab[r].ok; limpa_erro = tab[r].l;
            for (int k = 0; k < tab[r].n; k++) begin
                @(posedge clk);
                #1;
                chk($sformatf("row%0d_cyc%0d", r, k), saidas, tab[r].exp);
            end
        end

        // Asynchronous reset in the middle of AGUA
        cafe = 1'b1; sopa = 1'b0; copo_ok = 1'b1; limpa_erro = 1'b0;
        @(posedge clk); #1; chk("rst_seq_accept", saidas, IDLE);
        for (int k = 0; k < 4; k++) begin @(posedge clk); #1; chk("rst_seq_copo", saidas, MOT); end
        for (int k = 0; k < 3; k++) begin @(posedge clk); #1; chk("rst_seq_po", saidas, POC); end
        for (int k = 0; k < 3; k++) begin @(posedge clk); #1; chk("rst_seq_agua", saidas, AGU); end
        cafe = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("rst_async_drop", saidas, IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1; chk("rst_after_idle", saidas, IDLE);
        cafe = 1'b1;
        @(posedge clk); #1; chk("rst_restart_accept", saidas, IDLE);
        @(posedge clk); #1; chk("rst_restart_copo", saidas, MOT);
        cafe = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
